// File: rtl/key_event_conditioner.sv
// key_event_conditioner
// Conditions the eight raw piano key switches and the song-start button for
// the guided-play note counter: 2-FF synchronizers, per-channel debounce,
// rising-edge detection, key press strobe with priority-encoded index, and a
// start trigger strobe.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required before a clean level changes (>= 2)
// Ports:
//   clk_in         system clock
//   rst_in         synchronous active-high reset
//   keys_raw[7:0]  raw key switches, bit 0 = low C
//   btn_raw        raw song-start button
//   keys_clean     debounced key levels
//   key_pulse      one-cycle strobe for a newly pressed key
//   key_index      lowest-index key of the most recent key_pulse (held)
//   multi_key      with key_pulse: more than one key rose in that cycle
//   trigger_pulse  one-cycle strobe on a debounced button press
// Configuration:
//   KEY_LOCKOUT_EN  when defined, after a key_pulse further key presses are
//                   ignored until all keys are released.
module key_event_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] keys_raw,
   input  logic       btn_raw,
   output logic [7:0] keys_clean,
   output logic       key_pulse,
   output logic [2:0] key_index,
   output logic       multi_key,
   output logic       trigger_pulse
);

   localparam int unsigned N_CH  = 9;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   // Toggle on the increment that would land on DEBOUNCE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic [N_CH-1:0]            sync1_q, sync1_d;
   logic [N_CH-1:0]            sync2_q, sync2_d;
   logic [N_CH-1:0]            clean_q, clean_d;
   logic [N_CH-1:0]            clean_dly_q, clean_dly_d;
   logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                       key_pulse_q, key_pulse_d;
   logic [2:0]                 key_index_q, key_index_d;
   logic                       multi_key_q, multi_key_d;
   logic                       trigger_pulse_q, trigger_pulse_d;

   logic [N_CH-1:0] rise_c;
   logic [7:0]      key_rise_c;
   logic [2:0]      first_c;
   logic            multi_c;
   logic            accept_c;

   // Synchronizers and per-channel debounce; channel 8 is the button.
   always_comb begin
      sync1_d     = {btn_raw, keys_raw};
      sync2_d     = sync1_q;
      clean_d     = clean_q;
      cnt_d       = cnt_q;
      clean_dly_d = clean_q;
      for (int i = 0; i < N_CH; i++) begin
         if (sync2_q[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            clean_d[i] = ~clean_q[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Rising edges, lowest-index priority encode, and more-than-one-bit test.
   always_comb begin
      rise_c     = clean_q & ~clean_dly_q;
      key_rise_c = rise_c[7:0];
      first_c    = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (key_rise_c[i]) first_c = 3'(i);
      end
      multi_c = (key_rise_c & (key_rise_c - 8'd1)) != 8'd0;
   end

`ifdef KEY_LOCKOUT_EN
   typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} lock_state_e;
   lock_state_e state_q, state_d;

   // Lockout: one accepted press, then wait for every key to be released.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      case (state_q)
         ARMED: begin
            if (key_rise_c != 8'h00) begin
               accept_c = 1'b1;
               state_d  = LOCKED;
            end
         end
         LOCKED: begin
            if (clean_q[7:0] == 8'h00) state_d = ARMED;
         end
         default: state_d = ARMED;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= ARMED;
      else        state_q <= state_d;
   end
`else
   assign accept_c = key_rise_c != 8'h00;
`endif

   // Registered event outputs; key_index holds between accepted presses.
   always_comb begin
      key_pulse_d     = accept_c;
      multi_key_d     = accept_c & multi_c;
      key_index_d     = accept_c ? first_c : key_index_q;
      trigger_pulse_d = rise_c[8];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_q         <= '0;
         sync2_q         <= '0;
         clean_q         <= '0;
         clean_dly_q     <= '0;
         cnt_q           <= '0;
         key_pulse_q     <= 1'b0;
         key_index_q     <= 3'd0;
         multi_key_q     <= 1'b0;
         trigger_pulse_q <= 1'b0;
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         clean_q         <= clean_d;
         clean_dly_q     <= clean_dly_d;
         cnt_q           <= cnt_d;
         key_pulse_q     <= key_pulse_d;
         key_index_q     <= key_index_d;
         multi_key_q     <= multi_key_d;
         trigger_pulse_q <= trigger_pulse_d;
      end
   end

   assign keys_clean    = clean_q[7:0];
   assign key_pulse     = key_pulse_q;
   assign key_index     = key_index_q;
   assign multi_key     = multi_key_q;
   assign trigger_pulse = trigger_pulse_q;

endmodule

// File: tb/tb_key_event_conditioner.sv
// Testbench for key_event_conditioner: directed scenarios plus random key and
// button activity, checked by a scoreboard fed from a behavioural model.
module tb_key_event_conditioner;

   localparam int unsigned D   = 4;
   localparam int unsigned WIN = D - 1;   // sync2 samples that must all differ

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [7:0] keys_raw;
   logic       btn_raw;
   logic [7:0] keys_clean;
   logic       key_pulse;
   logic [2:0] key_index;
   logic       multi_key;
   logic       trigger_pulse;

   always #5 clk_in = ~clk_in;

   key_event_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .keys_raw     (keys_raw),
      .btn_raw      (btn_raw),
      .keys_clean   (keys_clean),
      .key_pulse    (key_pulse),
      .key_index    (key_index),
      .multi_key    (multi_key),
      .trigger_pulse(trigger_pulse)
   );

   typedef struct { int cyc; bit kp; bit multi; bit trig; } evt_t;
   typedef struct { logic [7:0] clean; logic [2:0] idx; bit rst; } lvl_t;

   evt_t evt_q[$];
   lvl_t lvl_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: a level flips once the last WIN synchronized samples
   // all disagree with it; events fire one cycle after a clean rise.
   logic [8:0] m_s1, m_s2, m_clean, m_clean_dly, m_new, m_rise;
   logic [8:0] m_hist[$];
   logic [7:0] m_kr;
   logic [2:0] m_idx;
   bit         m_armed, m_fire, m_diff;
   int         m_n, m_lo;

   initial begin
      forever begin
         @(posedge clk_in);
         cyc++;
         if (rst_in) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_clean_dly = '0;
            m_hist.delete();
            m_armed = 1'b1;
            m_idx   = 3'd0;
            lvl_q.push_back('{8'h00, 3'd0, 1'b1});
         end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > WIN) void'(m_hist.pop_front());
            m_new = m_clean;
            if (m_hist.size() == WIN) begin
               for (int b = 0; b < 9; b++) begin
                  m_diff = 1'b1;
                  foreach (m_hist[j]) if (m_hist[j][b] == m_clean[b]) m_diff = 1'b0;
                  if (m_diff) m_new[b] = ~m_clean[b];
               end
            end
            m_rise = m_clean & ~m_clean_dly;
            m_kr   = m_rise[7:0];
            m_n    = $countones(m_kr);
            m_fire = (m_n > 0);
`ifdef KEY_LOCKOUT_EN
            if (!m_armed) begin
               m_fire = 1'b0;
               if (m_clean[7:0] == 8'h00) m_armed = 1'b1;
            end else if (m_fire) begin
               m_armed = 1'b0;
            end
`endif
            if (m_fire) begin
               m_lo = 0;
               while (!m_kr[m_lo]) m_lo++;
               m_idx = 3'(m_lo);
            end
            if (m_fire || m_rise[8])
               evt_q.push_back('{cyc, m_fire, m_fire && (m_n > 1), m_rise[8]});
            m_clean_dly = m_clean;
            m_clean     = m_new;
            m_s2        = m_s1;
            m_s1        = {btn_raw, keys_raw};
            lvl_q.push_back('{m_clean[7:0], m_idx, 1'b0});
         end
      end
   end

   // Monitor: compares levels every cycle and pops an event whenever the DUT strobes.
   lvl_t mon_l;
   evt_t mon_e;
   initial begin
      forever begin
         @(negedge clk_in);
         if (lvl_q.size() > 0) begin
            mon_l = lvl_q.pop_front();
            check("keys_clean", 32'(keys_clean), 32'(mon_l.clean));
            check("key_index", 32'(key_index), 32'(mon_l.idx));
            if (mon_l.rst) begin
               check("reset_key_pulse", 32'(key_pulse), 32'd0);
               check("reset_multi_key", 32'(multi_key), 32'd0);
               check("reset_trigger", 32'(trigger_pulse), 32'd0);
            end
         end
         while (evt_q.size() > 0 && evt_q[0].cyc < cyc) begin
            mon_e = evt_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: no strobe seen, expected one at cycle %0d (now %0d)",
                     mon_e.cyc, cyc);
         end
         if (key_pulse || trigger_pulse || multi_key) begin
            if (evt_q.size() > 0 && evt_q[0].cyc == cyc) begin
               mon_e = evt_q.pop_front();
               check("key_pulse", 32'(key_pulse), 32'(mon_e.kp));
               check("multi_key", 32'(multi_key), 32'(mon_e.multi));
               check("trigger_pulse", 32'(trigger_pulse), 32'(mon_e.trig));
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: key_pulse=%0b trigger=%0b multi=%0b, none expected at cycle %0d",
                        key_pulse, trigger_pulse, multi_key, cyc);
            end
         end
      end
   end

   task automatic hold(input logic [7:0] k, input logic b, input int unsigned n);
      keys_raw = k;
      btn_raw  = b;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   logic [7:0] rk;
   int         r;
   initial begin
      rst_in   = 1'b1;
      keys_raw = 8'hFF;
      btn_raw  = 1'b0;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;

      // All keys held through reset: exact latency after release.
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk_in);
         #1;
         if (k == 4) check("dir_clean_not_yet", 32'(keys_clean), 32'h00);
         if (k == 5) begin
            check("dir_clean_at_5", 32'(keys_clean), 32'hFF);
            check("dir_no_pulse_at_5", 32'(key_pulse), 32'd0);
         end
         if (k == 6) begin
            check("dir_pulse_at_6", 32'(key_pulse), 32'd1);
            check("dir_index_at_6", 32'(key_index), 32'd0);
            check("dir_multi_at_6", 32'(multi_key), 32'd1);
         end
      end
      @(posedge clk_in);
      #1 check("dir_pulse_one_cycle", 32'(key_pulse), 32'd0);
      hold(8'h00, 1'b0, 12);

      // Bounce on key 3, then a stable press.
      for (int i = 0; i < 10; i++) begin
         hold(8'h08, 1'b0, 1);
         hold(8'h00, 1'b0, 1);
      end
      hold(8'h08, 1'b0, 15);
      hold(8'h00, 1'b0, 12);

      // Sequential presses of keys 5 and 2.
      hold(8'h20, 1'b0, 10);
      hold(8'h00, 1'b0, 10);
      hold(8'h04, 1'b0, 10);
      hold(8'h00, 1'b0, 10);

      // Simultaneous keys 6 and 1.
      hold(8'h42, 1'b0, 10);
      hold(8'h00, 1'b0, 10);

      // Button together with key 7.
      hold(8'h80, 1'b1, 10);
      hold(8'h00, 1'b0, 10);

      // Key 4 pressed while key 0 held, then key 4 alone.
      hold(8'h01, 1'b0, 10);
      hold(8'h11, 1'b0, 10);
      hold(8'h00, 1'b0, 10);
      hold(8'h10, 1'b0, 10);
      hold(8'h00, 1'b0, 10);

      // Random activity: glitches, held chords, button presses, mid-run resets.
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            rst_in = 1'b1;
            hold(keys_raw, btn_raw, $urandom_range(1, 3));
            rst_in = 1'b0;
         end else if (r < 40) begin
            rk = keys_raw;
            rk[$urandom_range(0, 7)] ^= 1'b1;
            hold(rk, btn_raw ^ ($urandom_range(0, 4) == 0), $urandom_range(1, 2));
         end else begin
            hold(8'($urandom) & 8'($urandom) & 8'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(1, 10));
         end
      end

      hold(8'h00, 1'b0, 20);
      check("events_drained", 32'(evt_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
